z_core_inst_encoder: RTL and testbench

- Streaming RV32I instruction encoder: packs op/register/funct/immediate fields into a 32-bit instruction word per format (R/I/S/B/U/J).
- Exact inverse of the core's field decoder; feeds the debug instruction-injection path and the boot-ROM/self-test stream generator.
- Valid/ready on both sides, 1-cycle encode latency, small output FIFO for backpressure, per-word error flag and word counter.

---
 rtl/z_core_inst_encoder.sv | 140 ++++++++++++++
 tb/tb_z_core_inst_encoder.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/z_core_inst_encoder.sv
// z_core_inst_encoder: streaming RV32I instruction encoder.
// Packs op/register/funct/immediate fields into a 32-bit instruction word
// (R/I/S/B/U/J), queues it with an error flag in a small output FIFO and
// counts delivered words.
// Optional macro Z_CORE_ENC_RANGE_CHECK_EN adds immediate range checking
// to the error flag; without it only an illegal format raises the flag.
module z_core_inst_encoder #(
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_fmt,
  input  logic [6:0]       in_op,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic             out_err,
  output logic [CNT_W-1:0] enc_count
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_OCC = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_t;

  logic [31:0]      enc_inst;
  logic             illegal_fmt;
  logic             enc_err;

  logic [32:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   occ;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  // Field packing per instruction format; illegal formats encode to zero.
  always_comb begin
    enc_inst    = 32'h0000_0000;
    illegal_fmt = 1'b0;
    case (fmt_t'(in_fmt))
      FMT_R: enc_inst = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_op};
      FMT_I: enc_inst = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_op};
      FMT_S: enc_inst = {in_imm[11:5], in_rs2, in_rs1, in_funct3,
                         in_imm[4:0], in_op};
      FMT_B: enc_inst = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                         in_imm[4:1], in_imm[11], in_op};
      FMT_U: enc_inst = {in_imm[31:12], in_rd, in_op};
      FMT_J: enc_inst = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                         in_rd, in_op};
      default: illegal_fmt = 1'b1;
    endcase
  end

`ifdef Z_CORE_ENC_RANGE_CHECK_EN
  logic range_err;

  // An immediate fits when all bits above the field's sign bit replicate it;
  // branch and jump offsets must also be even.
  always_comb begin
    range_err = 1'b0;
    case (fmt_t'(in_fmt))
      FMT_I, FMT_S: range_err = (in_imm[31:11] != {21{in_imm[11]}});
      FMT_B:        range_err = (in_imm[31:12] != {20{in_imm[12]}}) | in_imm[0];
      FMT_J:        range_err = (in_imm[31:20] != {12{in_imm[20]}}) | in_imm[0];
      FMT_U:        range_err = (in_imm[11:0] != 12'h000);
      default:      range_err = 1'b0;
    endcase
  end

  assign enc_err = illegal_fmt | range_err;
`else
  assign enc_err = illegal_fmt;
`endif

  assign full      = (occ == FULL_OCC);
  assign empty     = (occ == '0);
  assign in_ready  = rstn & ~full;
  assign out_valid = ~empty;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_inst  = empty ? 32'h0000_0000 : mem[rd_ptr][32:1];
  assign out_err   = empty ? 1'b0 : mem[rd_ptr][0];

  // Storage array; the tail slot is never the presented head while pushing.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {enc_inst, enc_err};
    end
  end

  // Pointer and occupancy bookkeeping; reset discards everything queued.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   occ <= occ + (PTR_W + 1)'(1);
        2'b01:   occ <= occ - (PTR_W + 1)'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Delivered-word counter, wraps naturally at its width.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      enc_count <= '0;
    end else if (pop) begin
      enc_count <= enc_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_z_core_inst_encoder.sv
// Testbench for z_core_inst_encoder: scoreboard-checked directed and random
// streams, with a field-arithmetic reference model for the encoding.
// Expected error flags follow Z_CORE_ENC_RANGE_CHECK_EN when it is defined.
module tb_z_core_inst_encoder;

  localparam int FIFO_DEPTH = 2;
  localparam int CNT_W      = 4;
`ifdef Z_CORE_ENC_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] inst;
    logic        err;
  } exp_t;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [2:0]       in_fmt = '0;
  logic [6:0]       in_op = '0;
  logic [4:0]       in_rd = '0;
  logic [4:0]       in_rs1 = '0;
  logic [4:0]       in_rs2 = '0;
  logic [2:0]       in_funct3 = '0;
  logic [6:0]       in_funct7 = '0;
  logic [31:0]      in_imm = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_inst;
  logic             out_err;
  logic [CNT_W-1:0] enc_count;

  exp_t             sb[$];
  exp_t             mon_e;
  logic [CNT_W-1:0] hs_count = '0;
  int               tests = 0;
  int               fails = 0;

  z_core_inst_encoder #(.FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_err(out_err), .enc_count(enc_count)
  );

  always #5 clk = ~clk;

  // One comparison: count it, and report it if it does not hold.
  task automatic checkOutput(input string name, input logic [32:0] act,
                             input logic [32:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Extract bits hi..lo of x as a plain number.
  function automatic int unsigned fld(input int unsigned x, input int hi,
                                      input int lo);
    int unsigned mask;
    mask = (32'd1 << (hi - lo + 1)) - 32'd1;
    return (x >> lo) & mask;
  endfunction

  // Reference model: builds the word by placing each field value at its
  // bit position, and judges immediate ranges with signed integer limits.
  function automatic exp_t model(input logic [2:0] f, input logic [6:0] op,
                                 input logic [4:0] rd, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic [2:0] f3,
                                 input logic [6:0] f7, input logic [31:0] imm);
    exp_t r;
    int unsigned o, d, a, b, t, s7, u, w;
    int si;
    o = 32'(op); d = 32'(rd); a = 32'(rs1); b = 32'(rs2);
    t = 32'(f3); s7 = 32'(f7); u = imm; si = $signed(imm);
    w = 0;
    r.err = 1'b0;
    case (f)
      3'd0: w = o | (d << 7) | (t << 12) | (a << 15) | (b << 20) | (s7 << 25);
      3'd1: begin
        w = o | (d << 7) | (t << 12) | (a << 15) | (fld(u, 11, 0) << 20);
        r.err = RC && (si < -2048 || si > 2047);
      end
      3'd2: begin
        w = o | (fld(u, 4, 0) << 7) | (t << 12) | (a << 15) | (b << 20)
              | (fld(u, 11, 5) << 25);
        r.err = RC && (si < -2048 || si > 2047);
      end
      3'd3: begin
        w = o | (fld(u, 11, 11) << 7) | (fld(u, 4, 1) << 8) | (t << 12)
              | (a << 15) | (b << 20) | (fld(u, 10, 5) << 25)
              | (fld(u, 12, 12) << 31);
        r.err = RC && (si < -4096 || si > 4094 || (u % 2) != 0);
      end
      3'd4: begin
        w = o | (d << 7) | (u - (u % 4096));
        r.err = RC && ((u % 4096) != 0);
      end
      3'd5: begin
        w = o | (d << 7) | (fld(u, 19, 12) << 12) | (fld(u, 11, 11) << 20)
              | (fld(u, 10, 1) << 21) | (fld(u, 20, 20) << 31);
        r.err = RC && (si < -1048576 || si > 1048574 || (u % 2) != 0);
      end
      default: begin
        w = 0;
        r.err = 1'b1;
      end
    endcase
    r.inst = w;
    return r;
  endfunction

  // One driver cycle: check in_ready/out_valid against the scoreboard
  // occupancy, drive the inputs, and record the expected word if accepted.
  task automatic applyStimulus(input logic v, input logic [2:0] f,
                               input logic [6:0] op, input logic [4:0] rd,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [2:0] f3, input logic [6:0] f7,
                               input logic [31:0] imm, input logic ordy,
                               input exp_t e, output logic acc);
    @(posedge clk);
    #1;
    checkOutput("in_ready", 33'(in_ready), 33'(sb.size() < FIFO_DEPTH));
    checkOutput("out_valid", 33'(out_valid), 33'(sb.size() != 0));
    in_valid = v; in_fmt = f; in_op = op; in_rd = rd; in_rs1 = rs1;
    in_rs2 = rs2; in_funct3 = f3; in_funct7 = f7; in_imm = imm;
    out_ready = ordy;
    acc = v && in_ready;
    if (acc) sb.push_back(e);
  endtask

  // Offer one word until it is accepted, within a bounded number of cycles.
  task automatic sendWord(input logic [2:0] f, input logic [6:0] op,
                          input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [2:0] f3,
                          input logic [31:0] imm, input logic ordy,
                          input exp_t e);
    logic acc;
    acc = 1'b0;
    for (int k = 0; k < 20 && !acc; k++)
      applyStimulus(1'b1, f, op, rd, rs1, rs2, f3, 7'd0, imm, ordy, e, acc);
    if (!acc) begin
      tests++; fails++;
      $display("[TB] FAIL accept_timeout: got no accept expected accept");
    end
  endtask

  task automatic idle(input int n, input logic ordy);
    logic acc;
    for (int k = 0; k < n; k++)
      applyStimulus(1'b0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0,
                    ordy, 33'd0, acc);
  endtask

  // Hold reset for one edge and check the cleared state right after it.
  task automatic doReset();
    @(posedge clk);
    #1;
    rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rst_out_valid", 33'(out_valid), 33'(0));
    checkOutput("rst_out_inst", 33'(out_inst), 33'(0));
    checkOutput("rst_out_err", 33'(out_err), 33'(0));
    checkOutput("rst_enc_count", 33'(enc_count), 33'(0));
    checkOutput("rst_in_ready", 33'(in_ready), 33'(0));
    rstn = 1'b1;
  endtask

  // Monitor: pops and compares every delivered word, tracks the counter.
  always @(negedge clk) begin
    if (!rstn) begin
      sb.delete();
      hs_count = '0;
    end else begin
      checkOutput("enc_count", 33'(enc_count), 33'(hs_count));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          tests++; fails++;
          $display("[TB] FAIL unexpected_word: got %h expected none", out_inst);
        end else begin
          mon_e = sb.pop_front();
          checkOutput("out_inst", 33'(out_inst), 33'(mon_e.inst));
          checkOutput("out_err", 33'(out_err), 33'(mon_e.err));
        end
        hs_count = hs_count + CNT_W'(1);
      end
    end
  end

  int bvals[13] = '{2047, 2048, -2048, -2049, 4094, 4096, -4096, -4098,
                    1048574, 1048576, -1048576, -1048578, 32'h1234_5000};

  initial begin
    logic acc;
    logic [2:0] f;
    logic [6:0] op, f7;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] f3;
    logic [31:0] imm;
    logic v, ordy;

    doReset();

    sendWord(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5, 1'b1, {32'h0050_0093, 1'b0});
    sendWord(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, -32'sd8, 1'b1, {32'hFE20_8CE3, 1'b0});
    sendWord(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'h800, 1'b1, {32'h0010_00EF, 1'b0});
    sendWord(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 32'h1234_5000, 1'b1, {32'h1234_52B7, 1'b0});
    sendWord(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048, 1'b1, {32'h8000_0093, RC});
    sendWord(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 32'd6, 1'b1, {32'h0000_0363, 1'b0});
    sendWord(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 32'd7, 1'b1, {32'h0000_0363, RC});
    sendWord(3'd6, 7'h13, 5'd1, 5'd3, 5'd4, 3'd2, 32'd5, 1'b1, {32'h0000_0000, 1'b1});
    sendWord(3'd7, 7'h7F, 5'd31, 5'd31, 5'd31, 3'd7, 32'hFFFF_FFFF, 1'b1, {32'h0000_0000, 1'b1});
    idle(4, 1'b1);

    // Backpressure: two words fill the FIFO, the third waits for space.
    sendWord(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5, 1'b0, {32'h0050_0093, 1'b0});
    sendWord(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'h800, 1'b0, {32'h0010_00EF, 1'b0});
    for (int k = 0; k < 2; k++)
      applyStimulus(1'b1, 3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0,
                    32'h1234_5000, 1'b0, {32'h1234_52B7, 1'b0}, acc);
    sendWord(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 32'h1234_5000, 1'b1, {32'h1234_52B7, 1'b0});
    idle(4, 1'b1);

    // Reset with two words queued, then a fresh encode.
    sendWord(3'd1, 7'h13, 5'd2, 5'd3, 5'd0, 3'd1, 32'd9, 1'b0, {32'h0091_9113, 1'b0});
    sendWord(3'd1, 7'h13, 5'd2, 5'd3, 5'd0, 3'd1, 32'd9, 1'b0, {32'h0091_9113, 1'b0});
    doReset();
    sendWord(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, -32'sd8, 1'b1, {32'hFE20_8CE3, 1'b0});
    idle(3, 1'b1);

    // Randomised stream with random backpressure.
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 9) < 7);
      ordy = ($urandom_range(0, 9) < 6);
      f = 3'($urandom_range(0, 7));
      op = 7'($urandom); rd = 5'($urandom); rs1 = 5'($urandom);
      rs2 = 5'($urandom); f3 = 3'($urandom); f7 = 7'($urandom);
      case ($urandom_range(0, 3))
        0: imm = $urandom;
        1: imm = 32'($signed($urandom_range(0, 8191)) - 4096);
        2: imm = bvals[$urandom_range(0, 12)];
        default: imm = 32'($signed($urandom_range(0, 4194303)) - 2097152);
      endcase
      applyStimulus(v, f, op, rd, rs1, rs2, f3, f7, imm, ordy,
                    model(f, op, rd, rs1, rs2, f3, f7, imm), acc);
    end

    // Drain with a bounded budget.
    for (int k = 0; k < 20 && sb.size() != 0; k++) idle(1, 1'b1);
    if (sb.size() != 0) begin
      tests++; fails++;
      $display("[TB] FAIL drain: got %0d words left expected 0", sb.size());
    end
    idle(2, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
